// File: rtl/and_bist_pkg.sv
// Shared types and constants for the AND-array BIST sequencer and its golden model.
package and_bist_pkg;

    localparam int unsigned NUM_RES = 5;
    localparam int unsigned PAT_W   = 8;

    localparam logic [PAT_W-1:0] PAT_FIRST_EXH  = 8'h00;
    localparam logic [PAT_W-1:0] PAT_FIRST_WALK = 8'h01;
    localparam logic [PAT_W-1:0] PAT_LAST       = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Walking-one runs 01..80 and finishes on FF; exhaustive simply counts up.
    function automatic logic [PAT_W-1:0] next_pat(input logic walk, input logic [PAT_W-1:0] pat);
        if (!walk) begin
            return PAT_W'(pat + PAT_W'(1));
        end
        if (pat == 8'h80) begin
            return PAT_LAST;
        end
        return PAT_W'(pat << 1);
    endfunction

endpackage

// File: rtl/and_bist_sequencer_if.sv
// Control/status and array-side signals of the BIST sequencer.
interface and_bist_sequencer_if
    import and_bist_pkg::*;
#(
    parameter int unsigned ERR_W = 8
);
    logic               ena;
    logic               start;
    logic               abort;
    logic               mode;
    logic [NUM_RES-1:0] dut_res;
    logic [PAT_W-1:0]   pat_out;
    logic               busy;
    logic               done;
    logic               pass;
    logic [ERR_W-1:0]   err_cnt;
    logic [PAT_W-1:0]   first_fail;

    modport master (
        output ena, start, abort, mode, dut_res,
        input  pat_out, busy, done, pass, err_cnt, first_fail
    );

    modport slave (
        input  ena, start, abort, mode, dut_res,
        output pat_out, busy, done, pass, err_cnt, first_fail
    );
endinterface

// File: rtl/and_ref_model.sv
// Combinational golden model of the AND array: four 2-input ANDs plus one 8-input AND.
module and_ref_model
    import and_bist_pkg::*;
(
    input  logic [PAT_W-1:0]   pat,
    output logic [NUM_RES-1:0] res_c
);
    always_comb begin
        res_c    = '0;
        res_c[0] = pat[1] & pat[0];
        res_c[1] = pat[3] & pat[2];
        res_c[2] = pat[5] & pat[4];
        res_c[3] = pat[7] & pat[6];
        res_c[4] = &pat;
    end
endmodule

// File: rtl/and_bist_sequencer.sv
// BIST sequencer: walks stimulus patterns over the AND array, waits RESP_LAT cycles,
// then checks the returned results against the golden model and logs mismatches.
module and_bist_sequencer
    import and_bist_pkg::*;
#(
    parameter int unsigned RESP_LAT = 1,
    parameter int unsigned ERR_W    = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    and_bist_sequencer_if.slave bus
);
    localparam int unsigned LAT_W = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic               mode_q, mode_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [PAT_W-1:0]   ff_q, ff_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;

    logic [NUM_RES-1:0] exp_c;
    logic               mismatch_c;

    and_ref_model u_ref (
        .pat   (pat_q),
        .res_c (exp_c)
    );

    assign mismatch_c = (bus.dut_res != exp_c);

    // Next-state logic; ena low leaves every register at its current value.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        lat_d   = lat_q;
        mode_d  = mode_q;
        err_d   = err_q;
        ff_d    = ff_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;

        if (bus.ena) begin
            if (bus.abort) begin
                state_d = ST_IDLE;
                pat_d   = '0;
                lat_d   = '0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (bus.start) begin
                            state_d = ST_SETTLE;
                            mode_d  = bus.mode;
                            pat_d   = bus.mode ? PAT_FIRST_WALK : PAT_FIRST_EXH;
                            lat_d   = '0;
                            err_d   = '0;
                            ff_d    = '0;
                            busy_d  = 1'b1;
                            done_d  = 1'b0;
                            pass_d  = 1'b0;
                        end
                    end
                    ST_SETTLE: begin
                        if (lat_q == LAT_W'(RESP_LAT - 1)) begin
                            state_d = ST_CHECK;
                        end else begin
                            lat_d = LAT_W'(lat_q + LAT_W'(1));
                        end
                    end
                    ST_CHECK: begin
                        // A zero count means no mismatch yet this run, so this one is the first.
                        if (mismatch_c) begin
                            if (err_q != '1) begin
                                err_d = ERR_W'(err_q + ERR_W'(1));
                            end
                            if (err_q == '0) begin
                                ff_d = pat_q;
                            end
                        end
                        if (pat_q == PAT_LAST) begin
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            pass_d  = !mismatch_c && (err_q == '0);
                        end else begin
                            state_d = ST_SETTLE;
                            pat_d   = next_pat(mode_q, pat_q);
                            lat_d   = '0;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            lat_q   <= '0;
            mode_q  <= 1'b0;
            err_q   <= '0;
            ff_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            lat_q   <= lat_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.pat_out    = pat_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_cnt    = err_q;
    assign bus.first_fail = ff_q;

endmodule
